// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Multiplies by radix-2 shift-add and divides by restoring division, one bit
// per cycle, working on operand magnitudes and fixing the sign on the way out.
// Divide-by-zero and signed overflow bypass the iteration with fixed results.
//
// Handshake: start_i is a level held by the pipeline while the M op sits in
// EX; the unit answers with stall_o until done_o pulses for one cycle with
// result_o valid, so the instruction advances on the edge after done_o.
// flush_i aborts any op that has not yet reached DONE.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [1:0]      dbg_state_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [2:0]          r_f3;
  logic                r_neg_res;   // product / quotient must be negated
  logic                r_neg_rem;   // remainder takes the sign of rs1
  logic [XLEN-1:0]     r_a;         // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0]     r_b;         // divisor magnitude
  logic [2*XLEN-1:0]   r_prod;      // {partial sum, remaining multiplier bits}
  logic [XLEN-1:0]     r_rem;       // partial remainder (always below the divisor)
  logic [CW-1:0]       r_cnt;
  logic                r_done;
  logic [XLEN-1:0]     r_result;

  // Operand decode on the live inputs, used only when an op is accepted in IDLE.
  logic            w_s1, w_s2, w_neg1, w_neg2, w_div0, w_ovf;
  logic [XLEN-1:0] w_mag1, w_mag2, w_special;

  assign w_s1   = (funct3_i == 3'b001) | (funct3_i == 3'b010) |
                  (funct3_i == 3'b100) | (funct3_i == 3'b110);
  assign w_s2   = (funct3_i == 3'b001) | (funct3_i == 3'b100) | (funct3_i == 3'b110);
  assign w_neg1 = w_s1 & rs1_i[XLEN-1];
  assign w_neg2 = w_s2 & rs2_i[XLEN-1];
  assign w_mag1 = w_neg1 ? -rs1_i : rs1_i;
  assign w_mag2 = w_neg2 ? -rs2_i : rs2_i;
  assign w_div0 = funct3_i[2] & (rs2_i == '0);
  assign w_ovf  = funct3_i[2] & ~funct3_i[0] & (rs1_i == MIN_NEG) & (rs2_i == '1);
  // funct3_i[1] separates remainder ops from quotient ops.
  assign w_special = w_div0 ? (funct3_i[1] ? rs1_i : '1)
                            : (funct3_i[1] ? '0 : MIN_NEG);

  // One shift-add multiply step: add multiplicand when the low multiplier bit is set.
  logic [XLEN:0]     w_acc;
  logic [2*XLEN-1:0] w_prod_nx;
  assign w_acc     = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_prod_nx = {w_acc, r_prod[XLEN-1:1]};

  // One restoring divide step: shift in the next dividend bit, try to subtract.
  logic [XLEN:0]   w_shift, w_diff;
  logic [XLEN-1:0] w_rem_nx, w_quo_nx;
  assign w_shift  = {r_rem, r_a[XLEN-1]};
  assign w_diff   = w_shift - {1'b0, r_b};
  assign w_rem_nx = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_quo_nx = {r_a[XLEN-2:0], ~w_diff[XLEN]};

  // Sign fix-up applied to the values produced by the final iteration.
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_final;
  assign w_prod_fix = r_neg_res ? -w_prod_nx : w_prod_nx;
  assign w_quo_fix  = r_neg_res ? -w_quo_nx : w_quo_nx;
  assign w_rem_fix  = r_neg_rem ? -w_rem_nx : w_rem_nx;

  // Select the architectural result for the captured op.
  always_comb begin
    w_final = '0;
    case (r_f3)
      3'b000:                 w_final = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_quo_fix;
      default:                w_final = w_rem_fix;
    endcase
  end

  // Control FSM and datapath registers; done is high exactly while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_f3      <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_prod    <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            r_f3      <= funct3_i;
            r_neg_res <= w_neg1 ^ w_neg2;
            r_neg_rem <= w_neg1;
            r_a       <= w_mag1;
            r_b       <= w_mag2;
            r_prod    <= {{XLEN{1'b0}}, w_mag2};
            r_rem     <= '0;
            r_cnt     <= '0;
            if (w_div0 || w_ovf) begin
              r_result <= w_special;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_f3[2]) begin
              r_rem <= w_rem_nx;
              r_a   <= w_quo_nx;
            end else begin
              r_prod <= w_prod_nx;
            end
            if (r_cnt == LAST_CNT) begin
              r_result <= w_final;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_o     = start_i & ~r_done & ~flush_i;
  assign busy_o      = (r_state == S_BUSY);
  assign done_o      = r_done;
  assign result_o    = r_result;
  assign dbg_state_o = r_state;

endmodule
